// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: shared ISA definitions for the 8-bit control path.
//   - instruction class encoding and the opcode prefixes that select it
//   - 3-bit register codes (x0,x1,y0,y1,r,m,i,dm) used as move sources
//   - write-enable indices and the immediate source select code
package cpu_isa_pkg;

  typedef enum logic [2:0] {
    ClsLoad,
    ClsMove,
    ClsAlu,
    ClsJmp,
    ClsJnz
  } insn_class_e;

  // Opcode prefixes, MSB-aligned in the instruction word.
  localparam logic       PFX_LOAD = 1'b0;
  localparam logic [1:0] PFX_MOVE = 2'b10;
  localparam logic [2:0] PFX_ALU  = 3'b110;
  localparam logic [3:0] PFX_JMP  = 4'b1110;
  localparam logic [3:0] PFX_JNZ  = 4'b1111;

  // Source register codes.
  localparam logic [2:0] X0 = 3'd0;
  localparam logic [2:0] X1 = 3'd1;
  localparam logic [2:0] Y0 = 3'd2;
  localparam logic [2:0] Y1 = 3'd3;
  localparam logic [2:0] R  = 3'd4;
  localparam logic [2:0] M  = 3'd5;
  localparam logic [2:0] I  = 3'd6;
  localparam logic [2:0] DM = 3'd7;

  localparam logic [3:0]  SRC_IMM = 4'd8;
  localparam int unsigned REG_R   = 8;

  function automatic insn_class_e decode_class(input logic [7:0] insn);
    if (insn[7] == PFX_LOAD)           return ClsLoad;
    else if (insn[7:6] == PFX_MOVE)    return ClsMove;
    else if (insn[7:5] == PFX_ALU)     return ClsAlu;
    else if (insn[7:4] == PFX_JMP)     return ClsJmp;
    else                               return ClsJnz;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// reset_sync: two-flop reset synchronizer.
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   sync_reset out  asserts immediately with reset, deasserts on the 2nd rising
//                   clk after reset falls
module reset_sync (
  input  logic clk,
  input  logic reset,
  output logic sync_reset
);

  logic stage_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q    <= 1'b1;
      sync_reset <= 1'b1;
    end else begin
      stage_q    <= 1'b0;
      sync_reset <= stage_q;
    end
  end

endmodule

// File: rtl/instruction_decoder.sv
// instruction_decoder: decodes the program-memory word into sequencer jump
// requests and datapath write enables/source select; holds the zero flag and
// the instruction register.
//   clk, reset      clock and asynchronous active-high reset
//   pm_data         instruction word for the current pc
//   alu_zero        ALU result-is-zero from the datapath
//   sync_reset      synchronized reset for sequencer/datapath
//   jmp, jmp_nz     jump requests; jmp_addr is the target page
//   dont_jmp        registered zero flag (suppresses jmp_nz in the sequencer)
//   reg_en          one-hot write enable; source_sel, imm, alu_func, i_inc
//   ir              instruction register (debug)
module instruction_decoder
  import cpu_isa_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pm_data,
  input  logic       alu_zero,
  output logic       sync_reset,
  output logic       jmp,
  output logic       jmp_nz,
  output logic [3:0] jmp_addr,
  output logic       dont_jmp,
  output logic [8:0] reg_en,
  output logic [3:0] source_sel,
  output logic [3:0] imm,
  output logic [4:0] alu_func,
  output logic       i_inc,
  output logic [7:0] ir
);

  logic       is_alu;
  logic [2:0] dst;
  logic [2:0] src;

  reset_sync u_reset_sync (
    .clk        (clk),
    .reset      (reset),
    .sync_reset (sync_reset)
  );

  always_comb begin
    reg_en     = '0;
    source_sel = '0;
    imm        = '0;
    alu_func   = '0;
    i_inc      = 1'b0;
    jmp        = 1'b0;
    jmp_nz     = 1'b0;
    jmp_addr   = '0;
    is_alu     = 1'b0;
    dst        = '0;
    src        = '0;
    if (!sync_reset) begin
      imm      = pm_data[3:0];
      alu_func = pm_data[4:0];
      unique case (decode_class(pm_data))
        ClsLoad: begin
          dst         = pm_data[6:4];
          reg_en[dst] = 1'b1;
          source_sel  = SRC_IMM;
          // An explicit write of i beats the post-increment.
          i_inc       = (dst == DM) && (dst != I);
        end
        ClsMove: begin
          dst         = pm_data[5:3];
          src         = pm_data[2:0];
          reg_en[dst] = 1'b1;
          source_sel  = {1'b0, src};
          i_inc       = ((dst == DM) || (src == DM)) && (dst != I);
        end
        ClsAlu: begin
          reg_en[REG_R] = 1'b1;
          is_alu        = 1'b1;
        end
        ClsJmp: begin
          jmp      = 1'b1;
          jmp_addr = pm_data[3:0];
        end
        ClsJnz: begin
          jmp_nz   = 1'b1;
          jmp_addr = pm_data[3:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir       <= '0;
      dont_jmp <= 1'b0;
    end else if (sync_reset) begin
      ir       <= '0;
      dont_jmp <= 1'b0;
    end else begin
      ir <= pm_data;
      if (is_alu) dont_jmp <= alu_zero;
    end
  end

endmodule

// File: tb/tb_instruction_decoder.sv
module tb_instruction_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pm_data;
  logic       alu_zero;
  logic       sync_reset;
  logic       jmp;
  logic       jmp_nz;
  logic [3:0] jmp_addr;
  logic       dont_jmp;
  logic [8:0] reg_en;
  logic [3:0] source_sel;
  logic [3:0] imm;
  logic [4:0] alu_func;
  logic       i_inc;
  logic [7:0] ir;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .pm_data    (pm_data),
    .alu_zero   (alu_zero),
    .sync_reset (sync_reset),
    .jmp        (jmp),
    .jmp_nz     (jmp_nz),
    .jmp_addr   (jmp_addr),
    .dont_jmp   (dont_jmp),
    .reg_en     (reg_en),
    .source_sel (source_sel),
    .imm        (imm),
    .alu_func   (alu_func),
    .i_inc      (i_inc),
    .ir         (ir)
  );

  typedef struct {
    logic [7:0] pm;
    logic       az;
    logic [8:0] reg_en;
    logic [3:0] src;
    logic [3:0] imm;
    logic [4:0] func;
    logic       i_inc;
    logic       jmp;
    logic       jnz;
    logic [3:0] addr;
    logic       flag_before;
    logic       flag_after;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " reg_en"}, 16'(reg_en), 16'h0);
    chk({tag, " source_sel"}, 16'(source_sel), 16'h0);
    chk({tag, " imm"}, 16'(imm), 16'h0);
    chk({tag, " alu_func"}, 16'(alu_func), 16'h0);
    chk({tag, " i_inc"}, 16'(i_inc), 16'h0);
    chk({tag, " jmp"}, 16'(jmp), 16'h0);
    chk({tag, " jmp_nz"}, 16'(jmp_nz), 16'h0);
    chk({tag, " jmp_addr"}, 16'(jmp_addr), 16'h0);
  endtask

  function automatic vec_t mk(logic [7:0] pm, logic az, logic [8:0] re, logic [3:0] src,
                              logic [3:0] im, logic [4:0] fn, logic ii, logic j, logic jn,
                              logic [3:0] ad, logic fb, logic fa);
    vec_t v;
    v.pm = pm; v.az = az; v.reg_en = re; v.src = src; v.imm = im; v.func = fn;
    v.i_inc = ii; v.jmp = j; v.jnz = jn; v.addr = ad; v.flag_before = fb; v.flag_after = fa;
    return v;
  endfunction

  initial begin
    //          pm    az reg_en  src  imm  func  ii j jn addr fb fa
    vecs.push_back(mk(8'h3A, 1'b0, 9'h008, 4'd8, 4'hA, 5'h1A, 0, 0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(8'h7C, 1'b1, 9'h080, 4'd8, 4'hC, 5'h1C, 1, 0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(8'hB7, 1'b0, 9'h040, 4'd7, 4'h7, 5'h17, 0, 0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(8'h84, 1'b0, 9'h001, 4'd4, 4'h4, 5'h04, 0, 0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(8'hC5, 1'b1, 9'h100, 4'd0, 4'h5, 5'h05, 0, 0, 0, 4'h0, 0, 1));
    vecs.push_back(mk(8'hF3, 1'b0, 9'h000, 4'd0, 4'h3, 5'h13, 0, 0, 1, 4'h3, 1, 1));
    vecs.push_back(mk(8'hE9, 1'b0, 9'h000, 4'd0, 4'h9, 5'h09, 0, 1, 0, 4'h9, 1, 1));
    vecs.push_back(mk(8'hC5, 1'b0, 9'h100, 4'd0, 4'h5, 5'h05, 0, 0, 0, 4'h0, 1, 0));
    vecs.push_back(mk(8'hF3, 1'b1, 9'h000, 4'd0, 4'h3, 5'h13, 0, 0, 1, 4'h3, 0, 0));
    vecs.push_back(mk(8'h9F, 1'b0, 9'h008, 4'd7, 4'hF, 5'h1F, 1, 0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(8'hBA, 1'b0, 9'h080, 4'd2, 4'hA, 5'h1A, 1, 0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(8'h65, 1'b0, 9'h040, 4'd8, 4'h5, 5'h05, 0, 0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(8'h20, 1'b0, 9'h004, 4'd8, 4'h0, 5'h00, 0, 0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(8'hA4, 1'b0, 9'h010, 4'd4, 4'h4, 5'h04, 0, 0, 0, 4'h0, 0, 0));
    vecs.push_back(mk(8'hDF, 1'b1, 9'h100, 4'd0, 4'hF, 5'h1F, 0, 0, 0, 4'h0, 0, 1));
    vecs.push_back(mk(8'hFF, 1'b0, 9'h000, 4'd0, 4'hF, 5'h1F, 0, 0, 1, 4'hF, 1, 1));

    // Power-on reset held 3 cycles with an alu op pending.
    reset    = 1'b1;
    pm_data  = 8'hC5;
    alu_zero = 1'b1;
    #1;
    chk("por sync_reset", 16'(sync_reset), 16'h1);
    chk_all_zero("por");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("por hold sync_reset", 16'(sync_reset), 16'h1);
      chk("por hold dont_jmp", 16'(dont_jmp), 16'h0);
      chk("por hold ir", 16'(ir), 16'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rel edge1 sync_reset", 16'(sync_reset), 16'h1);
    chk("rel edge1 ir", 16'(ir), 16'h0);
    chk("rel edge1 dont_jmp", 16'(dont_jmp), 16'h0);
    chk("rel edge1 reg_en", 16'(reg_en), 16'h0);
    @(posedge clk); #1;
    chk("rel edge2 sync_reset", 16'(sync_reset), 16'h0);
    chk("rel edge2 ir", 16'(ir), 16'h0);
    chk("rel edge2 dont_jmp", 16'(dont_jmp), 16'h0);
    chk("rel edge2 reg_en", 16'(reg_en), 16'h100);

    // Table-driven decode and flag sequence.
    foreach (vecs[k]) begin
      @(negedge clk);
      pm_data  = vecs[k].pm;
      alu_zero = vecs[k].az;
      #1;
      chk($sformatf("v%0d reg_en", k), 16'(reg_en), 16'(vecs[k].reg_en));
      chk($sformatf("v%0d source_sel", k), 16'(source_sel), 16'(vecs[k].src));
      chk($sformatf("v%0d imm", k), 16'(imm), 16'(vecs[k].imm));
      chk($sformatf("v%0d alu_func", k), 16'(alu_func), 16'(vecs[k].func));
      chk($sformatf("v%0d i_inc", k), 16'(i_inc), 16'(vecs[k].i_inc));
      chk($sformatf("v%0d jmp", k), 16'(jmp), 16'(vecs[k].jmp));
      chk($sformatf("v%0d jmp_nz", k), 16'(jmp_nz), 16'(vecs[k].jnz));
      chk($sformatf("v%0d jmp_addr", k), 16'(jmp_addr), 16'(vecs[k].addr));
      chk($sformatf("v%0d dont_jmp pre", k), 16'(dont_jmp), 16'(vecs[k].flag_before));
      @(posedge clk); #1;
      chk($sformatf("v%0d dont_jmp post", k), 16'(dont_jmp), 16'(vecs[k].flag_after));
      chk($sformatf("v%0d ir", k), 16'(ir), 16'(vecs[k].pm));
    end

    // Mid-run reset during an alu cycle with alu_zero=1; flag is currently 1.
    @(negedge clk);
    pm_data  = 8'hC5;
    alu_zero = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("mid sync_reset", 16'(sync_reset), 16'h1);
    chk("mid dont_jmp", 16'(dont_jmp), 16'h0);
    chk("mid ir", 16'(ir), 16'h0);
    chk_all_zero("mid");
    @(posedge clk); #1;
    chk("mid edge dont_jmp", 16'(dont_jmp), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid rel1 sync_reset", 16'(sync_reset), 16'h1);
    chk("mid rel1 reg_en", 16'(reg_en), 16'h0);
    chk("mid rel1 dont_jmp", 16'(dont_jmp), 16'h0);
    @(posedge clk); #1;
    chk("mid rel2 sync_reset", 16'(sync_reset), 16'h0);
    chk("mid rel2 reg_en", 16'(reg_en), 16'h100);
    chk("mid rel2 dont_jmp", 16'(dont_jmp), 16'h0);
    @(posedge clk); #1;
    chk("mid rel3 dont_jmp", 16'(dont_jmp), 16'h1);
    chk("mid rel3 ir", 16'(ir), 16'hC5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

Control-side partner of the program sequencer. Decodes the 8-bit instruction word read from program memory, drives the sequencer's jump request lines (`jmp`, `jmp_nz`, `jmp_addr`, `dont_jmp`) and the datapath's register write enables and source select. Holds the ALU zero flag and the instruction register. Also produces the `sync_reset` consumed by the sequencer and datapath.

## Interface
- No parameters; widths fixed by the ISA (8-bit instruction, 4-bit jump page).
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high master reset
- pm_data  in  8  instruction word for the current pc; valid for the whole cycle
- alu_zero  in  1  ALU result-is-zero, combinational from datapath
- sync_reset  out  1  reset to sequencer/datapath, async assert, sync deassert
- jmp  out  1  unconditional jump request
- jmp_nz  out  1  jump-if-not-zero request
- jmp_addr  out  4  jump page; sequencer targets {jmp_addr,4'h0}
- dont_jmp  out  1  registered zero flag; 1 suppresses jmp_nz
- reg_en  out  9  one-hot write enable: [0]x0 [1]x1 [2]y0 [3]y1 [4]o_reg [5]m [6]i [7]dm [8]r
- source_sel  out  4  0-7 register code (x0,x1,y0,y1,r,m,i,dm), 8 = immediate
- imm  out  4  immediate value = pm_data[3:0]
- alu_func  out  5  = pm_data[4:0]
- i_inc  out  1  post-increment request for i after dm access
- ir  out  8  instruction register (debug)

## Operation
- Instruction classes, decoded combinationally from pm_data:
  - load `0ddd_iiii`: reg_en[ddd]=1, source_sel=8.
  - move `10dd_dsss`: reg_en[ddd]=1, source_sel=sss.
  - alu `110f_ffff`: reg_en[8]=1. The flag updates.
  - jmp `1110_aaaa`: jmp=1, jmp_addr=aaaa.
  - jnz `1111_aaaa`: jmp_nz=1, jmp_addr=aaaa.
- Non-jump classes drive jmp=jmp_nz=0 and jmp_addr=0. Non-alu classes drive reg_en[8]=0.
- source_sel is 0 for alu/jmp/jnz.
- i_inc = 1 for load/move when dst=7, or when move src=7.
- i_inc is forced 0 when dst=6: an explicit i write wins over post-increment.
- Zero flag dont_jmp: loaded with alu_zero on the rising edge ending an alu-class cycle. Held otherwise.
- ir <= pm_data every edge.
- While sync_reset=1, all of the following are forced to 0: reg_en, i_inc, jmp, jmp_nz, jmp_addr, source_sel. ir and dont_jmp are held at 0.

## Timing
- Reset values (async on reset=1): sync_reset=1, dont_jmp=0, ir=8'h00, all decoded outputs 0.
- sync_reset deasserts on the 2nd rising clk after reset falls (two-flop synchronizer). It reasserts immediately on reset rising, including mid-instruction.
- Decode latency is 0 cycles: jmp/jmp_nz/reg_en are combinational from pm_data in the same cycle. The sequencer selects pm_addr in that same cycle.
- The zero flag is visible to a jnz no earlier than the cycle after the alu instruction.
- alu immediately followed by jnz uses the freshly written flag.
- jnz with dont_jmp=1 still drives jmp_nz=1; suppression is the sequencer's job.
- Reset asserted in the same cycle as an alu op: the flag stays 0, because async clear wins.

## Structure
- Package `cpu_isa_pkg`:
  - class opcode prefixes;
  - register codes X0..DM;
  - SRC_IMM=4'd8;
  - REG_R index 8.
- Sub-module `reset_sync`: 2-flop async-assert/sync-deassert synchronizer producing sync_reset.
- The remainder is one decode always-block plus the ir/flag registers.

## Test plan
- Reset: hold reset 3 cycles, release.
  - sync_reset stays 1 for exactly 2 further edges.
  - dont_jmp=0 and ir=00 throughout.
- Load: pm_data=8'h3A.
  - reg_en=9'h008, source_sel=8, imm=A, i_inc=0.
  - pm_data=8'h7C gives reg_en=9'h080 and i_inc=1.
- Move: pm_data=8'hB7 (dst=6, src=7).
  - reg_en=9'h040, source_sel=7, i_inc=0 (write wins).
  - pm_data=8'h84 gives reg_en=9'h001, source_sel=4.
- Flag then branch: pm_data=8'hC5 with alu_zero=1.
  - reg_en=9'h100 and source_sel=0 during that cycle.
  - dont_jmp=1 after the edge.
  - Next pm_data=8'hF3 gives jmp_nz=1, jmp_addr=3, dont_jmp=1.
  - Repeat with alu_zero=0: dont_jmp=0.
- Jump: pm_data=8'hE9 gives jmp=1, jmp_addr=9, reg_en=0, dont_jmp unchanged.
- Mid-run reset: assert reset asynchronously during an alu cycle with alu_zero=1.
  - All outputs zero immediately.
  - dont_jmp=0 after release.
  - Decoding resumes 2 edges after release.
